// File: rtl/peripheral_div.sv
// Memory-mapped sequential unsigned restoring divider (A / B -> quotient, remainder).
// Latency: register writes 1 cycle; reads 1 cycle (d_out valid after strobe edge); divide WIDTH+1 cycles from start.
// Backpressure: none; starts arriving while busy are dropped, software polls the done status bit.
module peripheral_div #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d_in,
   input  logic             cs,
   input  logic [4:0]       addr,
   input  logic             rd,
   input  logic             wr,
   output logic [31:0]      d_out
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [4:0] ADDR_A    = 5'h04;
   localparam logic [4:0] ADDR_B    = 5'h08;
   localparam logic [4:0] ADDR_INIT = 5'h0C;
   localparam logic [4:0] ADDR_QUO  = 5'h10;
   localparam logic [4:0] ADDR_STAT = 5'h14;
   localparam logic [4:0] ADDR_REM  = 5'h18;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] dvd_q;      // dividend shifts out the top, quotient bits shift in at the bottom
   logic [WIDTH-1:0] div_q;      // divisor captured at start
   logic [WIDTH-1:0] rem_q;      // partial remainder
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] quo_res_q, rem_res_q;
   logic             done_q;
   logic [31:0]      d_out_q;
   logic [31:0]      rdata_d;

   logic             wr_acc, rd_acc, start_req, start_acc;
   logic [WIDTH:0]   rem_shift, trial;
   logic             q_bit;

   assign wr_acc    = cs & wr;
   assign rd_acc    = cs & rd;
   assign start_req = wr_acc && (addr == ADDR_INIT) && d_in[0];

   // Partial remainder never exceeds the divisor, so one extra bit is enough to
   // tell a negative trial subtraction from a positive one.
   assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
   assign trial     = rem_shift - {1'b0, div_q};
   assign q_bit     = ~trial[WIDTH];

   assign d_out     = d_out_q;

   // Next-state logic: only IDLE accepts a start, RUN counts down, DONE lasts one cycle.
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               start_acc = 1'b1;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Software-visible operand registers, writable at any time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q <= '0;
         b_q <= '0;
      end else if (wr_acc) begin
         if (addr == ADDR_A) a_q <= d_in;
         if (addr == ADDR_B) b_q <= d_in;
      end
   end

   // Working copies: load on start, one restoring-division step per RUN cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dvd_q <= '0;
         div_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
      end else if (start_acc) begin
         dvd_q <= a_q;
         div_q <= b_q;
         rem_q <= '0;
         cnt_q <= CW'(WIDTH);
      end else if (state_q == S_RUN) begin
         rem_q <= q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
         dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // Result registers and done flag; results only change when an operation completes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         quo_res_q <= '0;
         rem_res_q <= '0;
         done_q    <= 1'b0;
      end else if (start_acc) begin
         done_q <= 1'b0;
      end else if (state_q == S_DONE) begin
         quo_res_q <= dvd_q;
         rem_res_q <= rem_q;
         done_q    <= 1'b1;
      end
   end

   // Read mux; unmapped offsets read as zero.
   always_comb begin
      rdata_d = '0;
      case (addr)
         ADDR_QUO:  rdata_d = 32'(quo_res_q);
         ADDR_STAT: rdata_d = {31'b0, done_q};
         ADDR_REM:  rdata_d = 32'(rem_res_q);
         default:   rdata_d = '0;
      endcase
   end

   // Registered read data, held between read strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    d_out_q <= '0;
      else if (rd_acc) d_out_q <= rdata_d;
   end

endmodule

// File: tb/tb_peripheral_div.sv
// Directed bench for peripheral_div: register map, divide results, latency, busy-start, reset abort.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there too.
// Status polling counts edges from the start edge (edge 0); done set at edge 17 is first read back at edge 18.
module tb_peripheral_div;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [W-1:0]  d_in = '0;
   logic          cs = 1'b0;
   logic [4:0]    addr = '0;
   logic          rd = 1'b0;
   logic          wr = 1'b0;
   logic [31:0]   d_out;

   int n_checks = 0;
   int n_fail   = 0;

   peripheral_div #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .d_in    (d_in),
      .cs      (cs),
      .addr    (addr),
      .rd      (rd),
      .wr      (wr),
      .d_out   (d_out)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [4:0] a, input logic [W-1:0] d);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
      @(posedge clk); #1;
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
      @(posedge clk); #1;
      cs = 1'b0; rd = 1'b0;
      d = d_out;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Back-to-back status reads; returns the edge index whose read first saw done=1, or -1.
   task automatic poll_done(input int first_edge, output int done_edge);
      logic [31:0] s;
      done_edge = -1;
      for (int e = first_edge; e < first_edge + 60; e++) begin
         bus_rd(5'h14, s);
         if (s[0]) begin
            done_edge = e;
            break;
         end
      end
   endtask

   task automatic start_and_check(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r);
      int          e;
      logic [31:0] v;
      bus_wr(5'h0C, 16'h0001);
      poll_done(1, e);
      check_val({tag, "_latency"}, e, 32'd18);
      bus_rd(5'h10, v);
      check_val({tag, "_quo"}, v, exp_q);
      bus_rd(5'h18, v);
      check_val({tag, "_rem"}, v, exp_r);
   endtask

   task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r);
      bus_wr(5'h04, a);
      bus_wr(5'h08, b);
      start_and_check(tag, exp_q, exp_r);
   endtask

   initial begin
      logic [31:0] v;
      int          e;

      // Reset and idle read-back
      idle(2);
      check_val("rst_dout", d_out, 32'h0);
      reset_n = 1'b1;
      idle(1);
      bus_rd(5'h10, v); check_val("rst_quo",  v, 32'h0);
      bus_rd(5'h14, v); check_val("rst_stat", v, 32'h0);
      bus_rd(5'h18, v); check_val("rst_rem",  v, 32'h0);

      // Basic divisions
      run_div("d100_7",    16'd100,  16'd7, 32'h0000_000E, 32'h0000_0002);
      run_div("dffff_1",   16'hFFFF, 16'd1, 32'h0000_FFFF, 32'h0000_0000);
      run_div("d5_9",      16'd5,    16'd9, 32'h0000_0000, 32'h0000_0005);
      run_div("d1234_0",   16'd1234, 16'd0, 32'h0000_FFFF, 32'h0000_04D2);

      // Unmapped accesses
      bus_wr(5'h00, 16'hABCD);
      bus_rd(5'h04, v); check_val("unmapped_rd_a",  v, 32'h0);
      bus_rd(5'h1C, v); check_val("unmapped_rd_1c", v, 32'h0);
      bus_rd(5'h10, v); check_val("unmapped_wr_quo", v, 32'h0000_FFFF);

      // Start while busy is ignored; A/B writes during RUN only affect the next operation
      bus_wr(5'h04, 16'd1000);
      bus_wr(5'h08, 16'd10);
      bus_wr(5'h0C, 16'h0001);          // edge 0
      idle(3);                          // edges 1..3
      bus_rd(5'h10, v);                 // edge 4
      check_val("busy_rd_prev_quo", v, 32'h0000_FFFF);
      bus_wr(5'h04, 16'd7);             // edge 5
      bus_wr(5'h08, 16'd1);             // edge 6
      bus_wr(5'h0C, 16'h0001);          // edge 7, dropped
      poll_done(8, e);
      check_val("busy_latency", e, 32'd18);
      bus_rd(5'h10, v); check_val("busy_quo", v, 32'd100);
      bus_rd(5'h18, v); check_val("busy_rem", v, 32'd0);
      start_and_check("after_busy", 32'd7, 32'd0);

      // Reset in the middle of an operation
      bus_wr(5'h04, 16'd100);
      bus_wr(5'h08, 16'd7);
      bus_wr(5'h0C, 16'h0001);          // edge 0
      idle(6);                          // edges 1..6
      bus_rd(5'h10, v);                 // edge 7
      check_val("abort_pre_quo", v, 32'd7);
      idle(1);                          // edge 8
      reset_n = 1'b0;
      #1;
      check_val("abort_dout_now", d_out, 32'h0);
      idle(2);
      reset_n = 1'b1;
      idle(25);
      bus_rd(5'h14, v); check_val("abort_stat", v, 32'h0);
      bus_rd(5'h10, v); check_val("abort_quo",  v, 32'h0);
      bus_rd(5'h18, v); check_val("abort_rem",  v, 32'h0);

      // Operands were cleared by reset: 0 / 0
      start_and_check("post_rst_zero", 32'h0000_FFFF, 32'h0);
      run_div("post_rst_100_7", 16'd100, 16'd7, 32'h0000_000E, 32'h0000_0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
